pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Stall/flush controller for the 5-stage RV32I pipeline.
- Drives the enable inputs of every pipeline register bank (PC, IF/ID, ID/EX, EX/MEM, MEM/WB, all built from dff) and the bubble-insert (flush) controls for IF/ID and ID/EX.
- Resolves load-use hazards, branch/jump redirects, and multi-cycle instruction and data memory waits.
- Tracks one wrong-path fetch in flight and keeps saturating performance counters.

Parameters:
- CNT_W, 32, width of stall_cnt and flush_cnt.
- REG_W, 5, register-index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_W  source register 1 of the instruction in ID.
- id_rs2  in  REG_W  source register 2 of the instruction in ID.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_W  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_br_taken  in  1  EX resolved a taken branch or jump; PC mux selects the target this cycle.
- imem_ready  in  1  instruction data valid this cycle.
- mem_req  in  1  MEM-stage instruction is a load or store.
- dmem_ready  in  1  data access completes this cycle.
- pc_en  out  1  PC register enable.
- ifid_en  out  1  IF/ID register enable.
- idex_en  out  1  ID/EX register enable.
- exmem_en  out  1  EX/MEM register enable.
- memwb_en  out  1  MEM/WB register enable.
- ifid_flush  out  1  IF/ID loads a NOP bubble; only meaningful with ifid_en=1.
- idex_flush  out  1  ID/EX loads a NOP bubble; only meaningful with idex_en=1.
- stall_cnt  out  CNT_W  cycles with pc_en=0 since reset.
- flush_cnt  out  CNT_W  taken redirects since reset.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN; stall_cnt=0; flush_cnt=0.
  - While rst=0, all *_en=0 and both flushes=0, forced combinationally.
- Control outputs are combinational from inputs and state; there is no added latency.
- Default with no condition active: all en=1, flushes=0.
- Conditions are evaluated in this priority order (first match wins):
  - DSTALL, when mem_req & ~dmem_ready:
    - All five en=0, flushes=0.
    - No other condition is acted on.
    - State unchanged.
  - REDIRECT, when ex_br_taken:
    - All en=1; ifid_flush=1; idex_flush=1.
    - flush_cnt increments.
    - If imem_ready=0, next state=DISCARD (the in-flight fetch is wrong-path).
    - A simultaneous load-use condition is ignored.
  - LOADUSE, when ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)):
    - pc_en=0, ifid_en=0; idex_en=1 with idex_flush=1; exmem_en=1, memwb_en=1.
  - FETCH_WAIT, when ~imem_ready:
    - pc_en=0; ifid_en=1 with ifid_flush=1; downstream en=1.
- FSM has two states:
  - RUN: normal operation as above.
  - DISCARD: a wrong-path fetch is still outstanding; the PC already holds the redirect target.
    - pc_en=0; ifid_en=1, ifid_flush=1.
    - idex/exmem/memwb en=1, unless DSTALL or LOADUSE applies.
    - When imem_ready=1: that beat is dropped (IF/ID still receives a bubble) and next state=RUN.
    - A new ex_br_taken while in DISCARD applies REDIRECT outputs and the state stays DISCARD.
    - DSTALL in DISCARD freezes everything and the state is held.
- The LOADUSE check uses REG_W-wide equality; x0 never creates a hazard.
- Counters:
  - stall_cnt increments on each clock edge where rst=1 and pc_en=0.
  - flush_cnt increments on each edge where REDIRECT was taken.
  - Both saturate at 2^CNT_W-1.
- Reset asserted mid-stall or in DISCARD returns the block immediately to RUN with all en=0.
- After reset release, the first cycle follows the normal rules.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 → pc_en=0, ifid_en=0, idex_flush=1, stall_cnt +1.
  - Same stimulus with ex_rd=0 → all en=1, no flush.
- Redirect: ex_br_taken=1, imem_ready=1, with a load-use condition also true → all en=1, ifid_flush=idex_flush=1, flush_cnt=1, state RUN.
- Wrong-path fetch:
  - ex_br_taken=1 with imem_ready=0 → DISCARD.
  - Hold imem_ready=0 for 3 cycles → pc_en=0, ifid_flush=1 each cycle.
  - Then imem_ready=1 → bubble is inserted, RUN on the next cycle; stall_cnt +4.
- Data stall priority: mem_req=1, dmem_ready=0 for 2 cycles with ex_br_taken=1 → all en=0, no flushes, flush_cnt unchanged.
  - dmem_ready=1 → REDIRECT outputs appear and flush_cnt increments.
- Reset mid-DISCARD: pull rst low asynchronously between clock edges → all en=0 immediately, counters 0.
  - After release with imem_ready=1 → all en=1 (RUN).
- Saturation: with CNT_W=4, hold imem_ready=0 for 20 cycles → stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the stall/flush controller.
// The datapath side is the master: it reports hazards and memory status.
// The controller side is the slave: it returns register enables, bubbles and counters.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
);
    // Hazard and memory status from the datapath
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_read;
    logic             ex_br_taken;
    logic             imem_ready;
    logic             mem_req;
    logic             dmem_ready;

    // Register-bank controls back to the datapath
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;

    // Performance counters
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_br_taken,
               imem_ready, mem_req, dmem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_br_taken,
               imem_ready, mem_req, dmem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline.
// Control outputs are purely combinational from inputs and state. A small FSM
// remembers that a wrong-path fetch is still in flight after a redirect, so its
// returning beat is turned into a bubble instead of entering ID.
module pipe_ctrl #(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave p
);
    typedef enum logic {RUN, DISCARD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [REG_W-1:0] ex_rd;
    logic             dstall, redirect, loaduse;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush;
    logic             redirect_take;

    assign ex_rd    = p.ex_rd;
    assign dstall   = p.mem_req & ~p.dmem_ready;
    assign redirect = p.ex_br_taken;
    // x0 is hard-wired zero, so a load targeting it never creates a hazard
    assign loaduse  = p.ex_mem_read & (ex_rd != '0) &
                      ((ex_rd == p.id_rs1) | (p.id_uses_rs2 & (ex_rd == p.id_rs2)));

    // Prioritised hazard resolution: DSTALL > REDIRECT > LOADUSE/DISCARD > FETCH_WAIT
    always_comb begin
        state_d       = state_q;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        redirect_take = 1'b0;

        if (!rst) begin
            // Reset forces every bank to hold, regardless of state
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = RUN;
        end else if (dstall) begin
            // A pending data access freezes the whole pipe; nothing else may move
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (redirect) begin
            // PC takes the target; the two younger instructions are squashed.
            // An unfinished fetch belongs to the old path and must be dropped later.
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            redirect_take = 1'b1;
            if (state_q == RUN && !p.imem_ready)
                state_d = DISCARD;
        end else if (state_q == DISCARD) begin
            // PC already holds the target; wait out the stale beat and bubble IF/ID
            pc_en = 1'b0;
            if (loaduse) begin
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else begin
                ifid_flush = 1'b1;
            end
            if (p.imem_ready)
                state_d = RUN;
        end else if (loaduse) begin
            // Hold PC and ID for one cycle, push a bubble into EX
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!p.imem_ready) begin
            // Fetch not back yet: keep PC, feed a bubble into ID
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    // Saturating counter next-state
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (redirect_take && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign p.pc_en      = pc_en;
    assign p.ifid_en    = ifid_en;
    assign p.idex_en    = idex_en;
    assign p.exmem_en   = exmem_en;
    assign p.memwb_en   = memwb_en;
    assign p.ifid_flush = ifid_flush;
    assign p.idex_flush = idex_flush;
    assign p.stall_cnt  = stall_cnt_q;
    assign p.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a 4-bit counter build so saturation is
// reachable. Each step drives one cycle of inputs and queues the hand-computed
// response; a monitor on the falling edge pops and compares.
module tb_pipe_ctrl;
    localparam int CNT_W = 4;
    localparam int REG_W = 5;

    logic clk;
    logic rst;

    pipe_ctrl_if #(.CNT_W(CNT_W), .REG_W(REG_W)) bus ();

    pipe_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .clk (clk),
        .rst (rst),
        .p   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // enf = {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    typedef struct {
        int             id;
        logic [6:0]     enf;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_step = 0;

    localparam logic [6:0] NORM  = 7'b1111100;
    localparam logic [6:0] FROZE = 7'b0000000;
    localparam logic [6:0] REDIR = 7'b1111111;
    localparam logic [6:0] LUSE  = 7'b0011101;
    localparam logic [6:0] BUBIF = 7'b0111110;

    // One cycle of stimulus: inputs change just after the rising edge
    task automatic step(input logic r, input logic br, input logic imem,
                        input logic mreq, input logic dmem, input logic mrd,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [6:0] enf, input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst                 = r;
        bus.ex_br_taken     = br;
        bus.imem_ready      = imem;
        bus.mem_req         = mreq;
        bus.dmem_ready      = dmem;
        bus.ex_mem_read     = mrd;
        bus.ex_rd           = rd;
        bus.id_rs1          = rs1;
        bus.id_rs2          = rs2;
        bus.id_uses_rs2     = u2;
        e.id  = n_step;
        e.enf = enf;
        e.sc  = sc[CNT_W-1:0];
        e.fc  = fc[CNT_W-1:0];
        exp_q.push_back(e);
        n_step++;
    endtask

    task automatic idle(input logic [6:0] enf, input int sc, input int fc);
        step(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, enf, sc, fc);
    endtask

    // Monitor: compare the combinational response mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [6:0] got;
            e   = exp_q.pop_front();
            got = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                   bus.ifid_flush, bus.idex_flush};
            n_chk++;
            if (got === e.enf) n_pass++;
            else $display("FAIL step%0d ctrl: got %b want %b", e.id, got, e.enf);
            n_chk++;
            if (bus.stall_cnt === e.sc) n_pass++;
            else $display("FAIL step%0d stall_cnt: got %0d want %0d", e.id, bus.stall_cnt, e.sc);
            n_chk++;
            if (bus.flush_cnt === e.fc) n_pass++;
            else $display("FAIL step%0d flush_cnt: got %0d want %0d", e.id, bus.flush_cnt, e.fc);
        end
    end

    initial begin
        rst = 1'b0;
        bus.ex_br_taken = 0; bus.imem_ready = 1; bus.mem_req = 0; bus.dmem_ready = 1;
        bus.ex_mem_read = 0; bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
        bus.id_uses_rs2 = 0;

        //    r br im mq dm mr rd rs1 rs2 u2  expect  sc fc
        // reset state
        step(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, FROZE, 0, 0);
        idle(NORM, 0, 0);
        // load-use on rs1, then x0 case, then rs2 with/without use flag
        step(1, 0, 1, 0, 1, 1, 5, 5, 0, 0, LUSE, 0, 0);
        idle(NORM, 1, 0);
        step(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, NORM, 1, 0);
        step(1, 0, 1, 0, 1, 1, 7, 3, 7, 1, LUSE, 1, 0);
        step(1, 0, 1, 0, 1, 1, 7, 3, 7, 0, NORM, 2, 0);
        // redirect beats a simultaneous load-use; stays in RUN
        step(1, 1, 1, 0, 1, 1, 5, 5, 0, 0, REDIR, 2, 0);
        idle(NORM, 2, 1);
        // wrong-path fetch: redirect with fetch pending, 3 waits, stale beat
        step(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, REDIR, 2, 1);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, BUBIF, 2, 2);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, BUBIF, 3, 2);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, BUBIF, 4, 2);
        step(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, BUBIF, 5, 2);
        idle(NORM, 6, 2);
        // plain fetch wait in RUN
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, BUBIF, 6, 2);
        idle(NORM, 7, 2);
        // data stall outranks redirect, then redirect goes through
        step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, FROZE, 7, 2);
        step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, FROZE, 8, 2);
        step(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, REDIR, 9, 2);
        idle(NORM, 9, 3);
        // data stall while in DISCARD holds the state
        step(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, REDIR, 9, 3);
        step(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, FROZE, 9, 4);
        idle(BUBIF, 10, 4);
        idle(NORM, 11, 4);
        // load-use while in DISCARD: hold ID, bubble into EX
        step(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, REDIR, 11, 4);
        step(1, 0, 1, 0, 1, 1, 9, 9, 0, 0, LUSE, 11, 5);
        idle(NORM, 12, 5);
        // reset pulled mid-DISCARD between edges
        step(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, REDIR, 12, 5);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, BUBIF, 12, 6);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, FROZE, 0, 0);
        idle(NORM, 0, 0);
        // redirect again inside DISCARD keeps DISCARD
        step(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, REDIR, 0, 0);
        step(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, REDIR, 0, 1);
        idle(BUBIF, 0, 2);
        idle(NORM, 1, 2);
        // stall counter saturation at 15
        for (int k = 0; k < 20; k++)
            step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, BUBIF, (k + 1 > 15) ? 15 : k + 1, 2);
        idle(NORM, 15, 2);
        // flush counter saturation at 15
        for (int k = 0; k < 16; k++)
            step(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, REDIR, 15, (k + 2 > 15) ? 15 : k + 2);
        idle(NORM, 15, 15);

        // drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && exp_q.size() > 0; w++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
